// File: rtl/fft_consts_pkg.sv
// Shared FFT datapath constants and types.
//   N_LOG2      : log2 of the default FFT frame length
//   complex_t   : packed complex sample (re in upper half, im in lower half)
//   DW_COMPLEX  : width of a packed complex_t
//   bank_idx_t  : index of a ping-pong bank
//   bitrev()    : reverses the low 'width' bits of an N_LOG2-bit value
package fft_consts;

    localparam int unsigned N_LOG2 = 10;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    localparam int unsigned DW_COMPLEX = $bits(complex_t);

    typedef logic bank_idx_t;

    // Reversing the whole vector puts the low 'width' bits at the top, so a
    // right shift by the unused bit count brings them back down in reverse.
    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v,
                                                  input int unsigned      width);
        logic [N_LOG2-1:0] full_rev;
        full_rev = {<<{v}};
        return full_rev >> (N_LOG2 - width);
    endfunction

endpackage

// File: rtl/fft_pingpong_buf_ram.sv
// fft_dp_ram: true dual-port RAM, read-first on each port, port A wins a
// same-address write collision. Read data appears RD_LATENCY (1 or 2) cycles
// after the edge at which the port enable is sampled. Output registers reset
// to zero; the array itself is not reset.
//   clk, rst_n                          : clock, synchronous active-low reset
//   ena, wea, addra, dina -> douta      : port A
//   enb, web, addrb, dinb -> doutb      : port B
module fft_dp_ram
    import fft_consts::*;
#(
    parameter int unsigned DEPTH_LOG2 = N_LOG2,
    parameter int unsigned DW         = DW_COMPLEX,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [DEPTH_LOG2-1:0] addra,
    input  logic [DW-1:0]         dina,
    output logic [DW-1:0]         douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [DEPTH_LOG2-1:0] addrb,
    input  logic [DW-1:0]         dinb,
    output logic [DW-1:0]         doutb
);

    logic [DW-1:0] mem [0:(1 << DEPTH_LOG2)-1];
    logic [DW-1:0] qa1, qb1, qa2, qb2;

    // Array write: B is scheduled first so a same-address A write overrides it.
    always_ff @(posedge clk) begin
        if (enb && web) mem[addrb] <= dinb;
        if (ena && wea) mem[addra] <= dina;
    end

    // First read stage; non-blocking sampling of mem gives read-first data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qa1 <= '0;
            qb1 <= '0;
        end else begin
            if (ena) qa1 <= mem[addra];
            if (enb) qb1 <= mem[addrb];
        end
    end

    // Second read stage, only selected when RD_LATENCY is 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qa2 <= '0;
            qb2 <= '0;
        end else begin
            qa2 <= qa1;
            qb2 <= qb1;
        end
    end

    assign douta = (RD_LATENCY == 2) ? qa2 : qa1;
    assign doutb = (RD_LATENCY == 2) ? qb2 : qb1;

endmodule

// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two-bank ping-pong frame buffer. The stream fills bank
// ~bank_sel through its port A while the FFT engine owns bank bank_sel through
// ports A/B. Banks swap when the fill bank is full and the engine is free or
// releasing its bank in the same cycle.
//   in_valid/in_ready/in_data : sample stream in; overrun is sticky
//   work_valid / work_done    : engine ownership handshake
//   ena..douta, enb..doutb    : engine RAM ports on the work bank
//   bank_sel                  : bank owned by the engine
module fft_pingpong_buf
    import fft_consts::*;
#(
    parameter int unsigned DEPTH_LOG2 = N_LOG2,
    parameter int unsigned DW         = DW_COMPLEX,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          BITREV_WR  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  overrun,
    output logic                  work_valid,
    input  logic                  work_done,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [DEPTH_LOG2-1:0] addra,
    input  logic [DW-1:0]         dina,
    output logic [DW-1:0]         douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [DEPTH_LOG2-1:0] addrb,
    input  logic [DW-1:0]         dinb,
    output logic [DW-1:0]         doutb,
    output bank_idx_t             bank_sel
);

    localparam int unsigned AW = DEPTH_LOG2;

    logic [AW:0]   fcnt;
    logic          fill_full;
    logic          work_free;
    logic          accept;
    logic          swap;
    logic [AW-1:0] waddr;
    bank_idx_t     sel_d1, sel_d2, sel_dly;

    logic [1:0]    r_ena, r_wea, r_enb, r_web;
    logic [AW-1:0] r_addra [2];
    logic [AW-1:0] r_addrb [2];
    logic [DW-1:0] r_dina  [2];
    logic [DW-1:0] r_dinb  [2];
    logic [DW-1:0] r_douta [2];
    logic [DW-1:0] r_doutb [2];

    assign in_ready = ~fill_full;
    assign accept   = in_valid & ~fill_full;
    assign swap     = fill_full & (work_free | work_done);

    // Stream write address, optionally in bit-reversed order.
    always_comb begin
        if (BITREV_WR) begin
            waddr = AW'(bitrev(N_LOG2'(fcnt[AW-1:0]), AW));
        end else begin
            waddr = fcnt[AW-1:0];
        end
    end

    // Fill counter, swap handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_sel   <= 1'b0;
            fcnt       <= '0;
            fill_full  <= 1'b0;
            work_free  <= 1'b1;
            work_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (swap) begin
                bank_sel   <= ~bank_sel;
                fcnt       <= '0;
                fill_full  <= 1'b0;
                work_free  <= 1'b0;
                work_valid <= 1'b1;
            end else begin
                if (accept) begin
                    fcnt <= fcnt + {{AW{1'b0}}, 1'b1};
                    if (fcnt[AW-1:0] == {AW{1'b1}}) fill_full <= 1'b1;
                end
                if (work_done && work_valid) begin
                    work_valid <= 1'b0;
                    work_free  <= 1'b1;
                end
            end
            if (in_valid && fill_full) overrun <= 1'b1;
        end
    end

    // bank_sel delayed to line up with read data of either latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_d1 <= 1'b0;
            sel_d2 <= 1'b0;
        end else begin
            sel_d1 <= bank_sel;
            sel_d2 <= sel_d1;
        end
    end

    // Route engine ports to the work bank and the stream writer to the fill
    // bank; engine writes are blocked while the engine does not own a frame.
    always_comb begin
        r_ena = 2'b00;
        r_wea = 2'b00;
        r_enb = 2'b00;
        r_web = 2'b00;
        for (int b = 0; b < 2; b++) begin
            r_addra[b] = '0;
            r_addrb[b] = '0;
            r_dina[b]  = '0;
            r_dinb[b]  = '0;
            if (b[0] == bank_sel) begin
                r_ena[b]   = ena;
                r_wea[b]   = wea & work_valid;
                r_addra[b] = addra;
                r_dina[b]  = dina;
                r_enb[b]   = enb;
                r_web[b]   = web & work_valid;
                r_addrb[b] = addrb;
                r_dinb[b]  = dinb;
            end else begin
                r_ena[b]   = accept;
                r_wea[b]   = accept;
                r_addra[b] = waddr;
                r_dina[b]  = in_data;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_dp_ram #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .DW         (DW),
            .RD_LATENCY (RD_LATENCY)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (r_ena[g]),
            .wea   (r_wea[g]),
            .addra (r_addra[g]),
            .dina  (r_dina[g]),
            .douta (r_douta[g]),
            .enb   (r_enb[g]),
            .web   (r_web[g]),
            .addrb (r_addrb[g]),
            .dinb  (r_dinb[g]),
            .doutb (r_doutb[g])
        );
    end

    assign sel_dly = (RD_LATENCY == 2) ? sel_d2 : sel_d1;
    assign douta   = r_douta[sel_dly];
    assign doutb   = r_doutb[sel_dly];

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Directed bench for fft_pingpong_buf with DEPTH_LOG2 = 3. Three instances
// share one stimulus: plain (latency 1), bit-reversed writes, and latency 2.
module tb_fft_pingpong_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        work_done;
    logic        ena, wea, enb, web;
    logic [2:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic        in_ready_p, overrun_p, work_valid_p, bank_sel_p;
    logic [31:0] douta_p, doutb_p;
    logic        in_ready_b, overrun_b, work_valid_b, bank_sel_b;
    logic [31:0] douta_b, doutb_b;
    logic        in_ready_l, overrun_l, work_valid_l, bank_sel_l;
    logic [31:0] douta_l, doutb_l;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp_plain;
        logic [31:0] exp_br;
    } rd_vec_t;

    rd_vec_t rv [8];

    always #5 clk = ~clk;

    fft_pingpong_buf #(.DEPTH_LOG2(3), .DW(32), .RD_LATENCY(1), .BITREV_WR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p),
        .in_data(in_data), .overrun(overrun_p), .work_valid(work_valid_p),
        .work_done(work_done), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_p), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb_p), .bank_sel(bank_sel_p));

    fft_pingpong_buf #(.DEPTH_LOG2(3), .DW(32), .RD_LATENCY(1), .BITREV_WR(1'b1)) dut_br (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .overrun(overrun_b), .work_valid(work_valid_b),
        .work_done(work_done), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_b), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb_b), .bank_sel(bank_sel_b));

    fft_pingpong_buf #(.DEPTH_LOG2(3), .DW(32), .RD_LATENCY(2), .BITREV_WR(1'b0)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .overrun(overrun_l), .work_valid(work_valid_l),
        .work_done(work_done), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_l), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb_l), .bank_sel(bank_sel_l));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Offer n samples base..base+n-1, one per cycle; leaves in_valid high.
    task automatic stream(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(base + i);
            step();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " bank_sel"},   {31'd0, bank_sel_p},   32'd0);
        check({tag, " work_valid"}, {31'd0, work_valid_p}, 32'd0);
        check({tag, " in_ready"},   {31'd0, in_ready_p},   32'd1);
        check({tag, " overrun"},    {31'd0, overrun_p},    32'd0);
        check({tag, " douta"},      douta_p,               32'd0);
        check({tag, " doutb"},      doutb_p,               32'd0);
        check({tag, " fcnt"},       {28'd0, dut.fcnt},     32'd0);
        check({tag, " l2 douta"},   douta_l,               32'd0);
    endtask

    initial begin
        rv[0] = '{3'd0, 32'd0, 32'd0};
        rv[1] = '{3'd1, 32'd1, 32'd4};
        rv[2] = '{3'd2, 32'd2, 32'd2};
        rv[3] = '{3'd3, 32'd3, 32'd6};
        rv[4] = '{3'd4, 32'd4, 32'd1};
        rv[5] = '{3'd5, 32'd5, 32'd5};
        rv[6] = '{3'd6, 32'd6, 32'd3};
        rv[7] = '{3'd7, 32'd7, 32'd7};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; work_done = 1'b0;
        ena = 1'b0; wea = 1'b0; addra = 3'd0; dina = 32'd0;
        enb = 1'b0; web = 1'b0; addrb = 3'd0; dinb = 32'd0;
        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Frame 1: samples 0..7 back to back, engine free.
        stream(0, 8);
        in_valid = 1'b0;
        check("f1 in_ready low after 8th", {31'd0, in_ready_p},   32'd0);
        check("f1 no swap yet",            {31'd0, work_valid_p}, 32'd0);
        check("f1 fcnt full",              {28'd0, dut.fcnt},     32'd8);
        step();
        check("f1 swap work_valid", {31'd0, work_valid_p}, 32'd1);
        check("f1 swap bank_sel",   {31'd0, bank_sel_p},   32'd1);
        check("f1 in_ready back",   {31'd0, in_ready_p},   32'd1);
        check("f1 no overrun",      {31'd0, overrun_p},    32'd0);
        check("f1 br bank_sel",     {31'd0, bank_sel_b},   32'd1);

        // Table-driven port A reads of the work bank.
        for (int k = 0; k < 8; k++) begin
            ena   = 1'b1;
            addra = rv[k].addr;
            step();
            check($sformatf("rd plain a%0d", k), douta_p, rv[k].exp_plain);
            check($sformatf("rd bitrev a%0d", k), douta_b, rv[k].exp_br);
            if (k > 0) check($sformatf("rd lat2 a%0d", k - 1), douta_l, rv[k - 1].exp_plain);
        end
        ena = 1'b0;
        step();
        check("rd lat2 a7", douta_l, 32'd7);

        // Engine write through B, read back through A.
        enb = 1'b1; web = 1'b1; addrb = 3'd2; dinb = 32'hAAAA_5555;
        step();
        enb = 1'b0; web = 1'b0;
        ena = 1'b1; addra = 3'd2;
        step();
        ena = 1'b0;
        check("B write A read", douta_p, 32'hAAAA_5555);

        // Same-address write collision: port A wins.
        ena = 1'b1; wea = 1'b1; addra = 3'd5; dina = 32'd1;
        enb = 1'b1; web = 1'b1; addrb = 3'd5; dinb = 32'd2;
        step();
        wea = 1'b0; web = 1'b0;
        step();
        ena = 1'b0; enb = 1'b0;
        check("collision A port", douta_p, 32'd1);
        check("collision B port", doutb_p, 32'd1);

        // Frame 2 while engine still owns frame 1; keep offering after full.
        stream(100, 8);
        check("f2 in_ready low",       {31'd0, in_ready_p}, 32'd0);
        check("f2 no overrun at fill", {31'd0, overrun_p},  32'd0);
        in_data = 32'd999;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        check("f2 overrun",          {31'd0, overrun_p},    32'd1);
        check("f2 in_ready held",    {31'd0, in_ready_p},   32'd0);
        check("f2 fcnt unchanged",   {28'd0, dut.fcnt},     32'd8);
        check("f2 bank_sel held",    {31'd0, bank_sel_p},   32'd1);
        check("f2 work_valid held",  {31'd0, work_valid_p}, 32'd1);

        // Read addr 3 one edge before the swap edge.
        ena = 1'b1; addra = 3'd3;
        step();
        ena = 1'b0;
        check("pre-swap read lat1", douta_p, 32'd3);
        work_done = 1'b1;
        step();
        work_done = 1'b0;
        check("done swap bank_sel",   {31'd0, bank_sel_p},   32'd0);
        check("done swap work_valid", {31'd0, work_valid_p}, 32'd1);
        check("done swap in_ready",   {31'd0, in_ready_p},   32'd1);
        check("overrun sticky",       {31'd0, overrun_p},    32'd1);
        step();
        check("lat2 old bank data",   douta_l,               32'd3);
        check("work_valid continuous",{31'd0, work_valid_p}, 32'd1);
        ena = 1'b1; addra = 3'd3;
        step();
        ena = 1'b0;
        check("new bank plain a3",  douta_p, 32'd103);
        check("new bank bitrev a3", douta_b, 32'd106);

        // Reset mid-frame after 5 samples.
        stream(50, 5);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check_reset_state("midreset");
        rst_n = 1'b1;

        // Engine write without ownership is dropped.
        ena = 1'b1; wea = 1'b1; addra = 3'd4; dina = 32'h0000_DEAD;
        step();
        wea = 1'b0;
        step();
        ena = 1'b0;
        check("write suppressed", douta_p, 32'd104);

        // Fresh frame after reset swaps normally.
        stream(200, 8);
        in_valid = 1'b0;
        check("f3 in_ready low", {31'd0, in_ready_p}, 32'd0);
        step();
        check("f3 swap work_valid", {31'd0, work_valid_p}, 32'd1);
        check("f3 swap bank_sel",   {31'd0, bank_sel_p},   32'd1);
        ena = 1'b1; addra = 3'd0;
        step();
        check("f3 a0", douta_p, 32'd200);
        addra = 3'd5;
        step();
        check("f3 a5", douta_p, 32'd205);
        check("f3 br a5", douta_b, 32'd205);
        addra = 3'd6;
        step();
        ena = 1'b0;
        check("f3 a6", douta_p, 32'd206);
        check("f3 br a6", douta_b, 32'd203);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
